// File: rtl/traffic_pkg.sv
// Shared definitions for the N-way traffic light controller: lamp codes,
// phase encoding and the per-way lamp lookup.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10
  } phase_t;

  // Lamp code shown by the served way in a given phase; all other ways are red.
  function automatic logic [2:0] light_code(input phase_t ph);
    case (ph)
      PH_GREEN:  light_code = LIGHT_GREEN;
      PH_YELLOW: light_code = LIGHT_YELLOW;
      default:   light_code = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase duration counter: counts 0..dur-1, done on the last count.
// Hold freezes the count and masks done so a held phase can never expire.
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_hold,
  input  logic [CNT_W-1:0] i_dur,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  // Count register: clear wins over hold, otherwise advance by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (!i_hold) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_done = !i_hold && (r_count == (i_dur - CNT_W'(1)));

endmodule

// File: rtl/traffic_light_controller_n.sv
// N-way intersection sequencer: one way at a time through
// GREEN -> YELLOW -> ALL_RED, with demand skipping, green extension and
// emergency preemption. All outputs are registered.
//
// state      | meaning
// PH_ALL_RED | clearance; every way red, next way chosen on expiry
// PH_GREEN   | active_way green; may extend or be held by preemption
// PH_YELLOW  | active_way yellow; always runs its full duration
module traffic_light_controller_n
  import traffic_pkg::*;
#(
  parameter int NUM_WAYS   = 4,
  parameter int GREEN_CYC  = 30,
  parameter int YELLOW_CYC = 5,
  parameter int ALLRED_CYC = 10,
  parameter int CNT_W      = 8,
  localparam int WAY_W     = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  skip_en,
  input  logic [NUM_WAYS-1:0]   car_present,
  input  logic                  emer_req,
  input  logic [WAY_W-1:0]      emer_way,
  output logic [3*NUM_WAYS-1:0] lights,
  output logic [WAY_W-1:0]      active_way,
  output logic [1:0]            phase,
  output logic                  emer_active
);

  phase_t                  r_phase;
  logic [WAY_W-1:0]        r_active_way;
  logic [3*NUM_WAYS-1:0]   r_lights;
  logic                    r_emer_active;

  phase_t                  w_phase_nxt;
  logic [WAY_W-1:0]        w_way_nxt;
  logic [3*NUM_WAYS-1:0]   w_lights_nxt;
  logic                    w_emer_nxt;
  logic                    w_clr;
  logic                    w_hold;
  logic                    w_done;
  logic [CNT_W-1:0]        w_dur;
  logic                    w_emer_valid;
  logic                    w_emer_match;
  logic [NUM_WAYS-1:0]     w_self;
  logic                    w_other_demand;
  logic [WAY_W-1:0]        w_inc_way;
  logic [WAY_W-1:0]        w_sel_way;
  logic [WAY_W-1:0]        w_idx;
  logic                    w_found;

  assign w_emer_valid   = emer_req && (int'(emer_way) < NUM_WAYS);
  assign w_emer_match   = w_emer_valid && (emer_way == r_active_way);
  assign w_self         = NUM_WAYS'(1) << r_active_way;
  assign w_other_demand = |(car_present & ~w_self);
  assign w_inc_way      = WAY_W'((int'(r_active_way) + 1) % NUM_WAYS);

  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_hold (w_hold),
    .i_dur  (w_dur),
    .o_done (w_done)
  );

  // Duration of the phase currently running.
  always_comb begin
    w_dur = CNT_W'(ALLRED_CYC);
    case (r_phase)
      PH_GREEN:  w_dur = CNT_W'(GREEN_CYC);
      PH_YELLOW: w_dur = CNT_W'(YELLOW_CYC);
      default:   w_dur = CNT_W'(ALLRED_CYC);
    endcase
  end

  // Next way: preemption target, else first demanding way after the current one, else plain rotation.
  always_comb begin
    w_found   = 1'b0;
    w_sel_way = w_inc_way;
    w_idx     = '0;
    if (w_emer_valid) begin
      w_sel_way = emer_way;
    end else if (skip_en) begin
      for (int k = 1; k <= NUM_WAYS; k++) begin
        w_idx = WAY_W'((int'(r_active_way) + k) % NUM_WAYS);
        if (!w_found && car_present[w_idx]) begin
          w_sel_way = w_idx;
          w_found   = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic for the phase FSM.
  always_comb begin
    w_phase_nxt = r_phase;
    w_way_nxt   = r_active_way;
    w_clr       = 1'b0;
    w_hold      = 1'b0;
    case (r_phase)
      PH_GREEN: begin
        if (w_emer_valid && !w_emer_match) begin
          w_phase_nxt = PH_YELLOW;
        end else if (w_emer_match) begin
          // Held green sits at count 0 so release gives a full green.
          w_hold = 1'b1;
          w_clr  = 1'b1;
        end else if (w_done) begin
          if (skip_en && !w_other_demand) begin
            w_clr = 1'b1;
          end else begin
            w_phase_nxt = PH_YELLOW;
          end
        end
      end
      PH_YELLOW: begin
        if (w_done) w_phase_nxt = PH_ALL_RED;
      end
      PH_ALL_RED: begin
        if (w_done) begin
          w_phase_nxt = PH_GREEN;
          w_way_nxt   = w_sel_way;
        end
      end
      default: w_phase_nxt = PH_ALL_RED;
    endcase
    if (w_phase_nxt != r_phase) w_clr = 1'b1;

    w_emer_nxt = (w_phase_nxt == PH_GREEN) && w_emer_valid && (w_way_nxt == emer_way);

    w_lights_nxt = {NUM_WAYS{LIGHT_RED}};
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (WAY_W'(i) == w_way_nxt) w_lights_nxt[3*i +: 3] = light_code(w_phase_nxt);
    end
  end

  // State and registered outputs update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase       <= PH_ALL_RED;
      r_active_way  <= WAY_W'(NUM_WAYS - 1);
      r_lights      <= {NUM_WAYS{LIGHT_RED}};
      r_emer_active <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_active_way  <= w_way_nxt;
      r_lights      <= w_lights_nxt;
      r_emer_active <= w_emer_nxt;
    end
  end

  assign lights      = r_lights;
  assign active_way  = r_active_way;
  assign phase       = r_phase;
  assign emer_active = r_emer_active;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Directed bench for traffic_light_controller_n: a timeline table for plain
// rotation plus hand-written skip, preemption, reset and 3-way sequences.
module tb_traffic_light_controller_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        skip_en = 1'b0;
  logic [3:0]  car_present = '0;
  logic        emer_req = 1'b0;
  logic [1:0]  emer_way = '0;
  logic [11:0] lights;
  logic [1:0]  active_way;
  logic [1:0]  phase;
  logic        emer_active;

  logic        skip3 = 1'b0;
  logic [2:0]  car3 = '0;
  logic        emer_req3 = 1'b0;
  logic [1:0]  emer_way3 = '0;
  logic [8:0]  lights3;
  logic [1:0]  active_way3;
  logic [1:0]  phase3;
  logic        emer_active3;

  int checks = 0;
  int failures = 0;
  int e = 0;

  always #5 clk = ~clk;

  traffic_light_controller_n dut (
    .clk(clk), .rst(rst), .skip_en(skip_en), .car_present(car_present),
    .emer_req(emer_req), .emer_way(emer_way), .lights(lights),
    .active_way(active_way), .phase(phase), .emer_active(emer_active)
  );

  traffic_light_controller_n #(.NUM_WAYS(3)) dut3 (
    .clk(clk), .rst(rst), .skip_en(skip3), .car_present(car3),
    .emer_req(emer_req3), .emer_way(emer_way3), .lights(lights3),
    .active_way(active_way3), .phase(phase3), .emer_active(emer_active3)
  );

  typedef struct {
    int          at;
    logic [1:0]  ph;
    logic [1:0]  way;
    logic [11:0] lt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // One clock: inputs and samples both live at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) cyc();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    e = 0;
  endtask

  task automatic chk_main(input string name, input logic [1:0] ph, input logic [1:0] way,
                          input logic [11:0] lt, input logic ea);
    chk({name, "_phase"}, 32'(phase), 32'(ph));
    chk({name, "_way"}, 32'(active_way), 32'(way));
    chk({name, "_lights"}, 32'(lights), 32'(lt));
    chk({name, "_emer"}, 32'(emer_active), 32'(ea));
  endtask

  int n;

  initial begin
    tbl = '{
      '{0,   2'b00, 2'd3, 12'h924},
      '{9,   2'b00, 2'd3, 12'h924},
      '{10,  2'b01, 2'd0, 12'h921},
      '{39,  2'b01, 2'd0, 12'h921},
      '{40,  2'b10, 2'd0, 12'h922},
      '{44,  2'b10, 2'd0, 12'h922},
      '{45,  2'b00, 2'd0, 12'h924},
      '{54,  2'b00, 2'd0, 12'h924},
      '{55,  2'b01, 2'd1, 12'h90C},
      '{144, 2'b00, 2'd2, 12'h924},
      '{145, 2'b01, 2'd3, 12'h324},
      '{189, 2'b00, 2'd3, 12'h924},
      '{190, 2'b01, 2'd0, 12'h921}
    };

    // Plain rotation, skip disabled, checked against the table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      run_to(tbl[i].at);
      chk_main($sformatf("rot_e%0d", tbl[i].at), tbl[i].ph, tbl[i].way, tbl[i].lt, 1'b0);
    end

    // Skip enabled with demand only on way 3: extended green, then way 1.
    @(negedge clk);
    skip_en = 1'b1;
    car_present = 4'b1000;
    do_reset();
    run_to(10);  chk_main("skip_first", 2'b01, 2'd3, 12'h324, 1'b0);
    run_to(40);  chk_main("skip_ext40", 2'b01, 2'd3, 12'h324, 1'b0);
    run_to(105); car_present = 4'b1010;
    run_to(129); chk_main("skip_last_green", 2'b01, 2'd3, 12'h324, 1'b0);
    run_to(130); chk_main("skip_yellow", 2'b10, 2'd3, 12'h524, 1'b0);
    run_to(134); chk_main("skip_yellow_end", 2'b10, 2'd3, 12'h524, 1'b0);
    run_to(135); chk_main("skip_allred", 2'b00, 2'd3, 12'h924, 1'b0);
    run_to(145); chk_main("skip_way1", 2'b01, 2'd1, 12'h90C, 1'b0);

    // Preemption to a different way truncates green at count 12.
    @(negedge clk);
    skip_en = 1'b0;
    car_present = '0;
    do_reset();
    run_to(22);
    emer_req = 1'b1;
    emer_way = 2'd2;
    run_to(23);  chk_main("pre_trunc", 2'b10, 2'd0, 12'h922, 1'b0);
    run_to(27);  chk_main("pre_yel_end", 2'b10, 2'd0, 12'h922, 1'b0);
    run_to(28);  chk_main("pre_allred", 2'b00, 2'd0, 12'h924, 1'b0);
    run_to(38);  chk_main("pre_green2", 2'b01, 2'd2, 12'h864, 1'b1);
    run_to(100); chk_main("pre_held", 2'b01, 2'd2, 12'h864, 1'b1);
    emer_req = 1'b0;
    run_to(101); chk_main("pre_release", 2'b01, 2'd2, 12'h864, 1'b0);
    run_to(129); chk_main("pre_last_green", 2'b01, 2'd2, 12'h864, 1'b0);
    run_to(130); chk_main("pre_yellow", 2'b10, 2'd2, 12'h8A4, 1'b0);
    run_to(145); chk_main("pre_resume_way3", 2'b01, 2'd3, 12'h324, 1'b0);

    // Preemption matching the green way freezes it; full green after release.
    do_reset();
    run_to(20);
    emer_req = 1'b1;
    emer_way = 2'd0;
    run_to(21); chk_main("hold_start", 2'b01, 2'd0, 12'h921, 1'b1);
    run_to(60); chk_main("hold_past_expiry", 2'b01, 2'd0, 12'h921, 1'b1);
    emer_req = 1'b0;
    n = 1;
    for (int g = 0; g < 100; g++) begin
      cyc();
      if (phase == 2'b01) n++;
      else break;
    end
    chk("hold_release_green_len", 32'(n), 32'd30);
    chk("hold_release_then_yellow", 32'(phase), 32'h2);

    // Asynchronous reset in the middle of yellow, then a clean restart.
    do_reset();
    run_to(42);
    chk("rstmid_pre_phase", 32'(phase), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk_main("rstmid_async", 2'b00, 2'd3, 12'h924, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    e = 0;
    run_to(9);  chk_main("rstmid_red9", 2'b00, 2'd3, 12'h924, 1'b0);
    run_to(10); chk_main("rstmid_green", 2'b01, 2'd0, 12'h921, 1'b0);

    // Three-way instance: rotation 0->1->2->0, out-of-range emer_way ignored.
    @(negedge clk);
    emer_req3 = 1'b1;
    emer_way3 = 2'd3;
    do_reset();
    run_to(10);  chk("n3_way0_lights", 32'(lights3), 32'h121);
    run_to(30);  chk("n3_no_trunc_phase", 32'(phase3), 32'h1);
    chk("n3_no_emer", 32'(emer_active3), 32'h0);
    run_to(55);  chk("n3_way1_lights", 32'(lights3), 32'h10C);
    run_to(100); chk("n3_way2_lights", 32'(lights3), 32'h064);
    chk("n3_way2_idx", 32'(active_way3), 32'h2);
    run_to(145); chk("n3_wrap_lights", 32'(lights3), 32'h121);
    chk("n3_wrap_idx", 32'(active_way3), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
